// File: rtl/mod_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch, decode, execute,
// memory and writeback sequencing with bus-wait timeout and sticky trap.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef OP_LUI
`define OP_LUI    7'h37
`define OP_AUIPC  7'h17
`define OP_JAL    7'h6F
`define OP_JALR   7'h67
`define OP_BRANCH 7'h63
`define OP_LOAD   7'h03
`define OP_STORE  7'h23
`define OP_IMM    7'h13
`define OP_OP     7'h33
`endif

module mod_multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES    = 16,
    parameter bit          RESET_STATE_FETCH = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [`OPCODE_WIDTH-1:0] opcode_i,
    input  logic                     branch_taken_i,
    input  logic                     imem_ack_i,
    input  logic                     dmem_ack_i,
    output logic                     imem_req_o,
    output logic                     dmem_req_o,
    output logic                     dmem_we_o,
    output logic                     ir_en_o,
    output logic                     pc_en_o,
    output logic [1:0]               pc_sel_o,
    output logic                     rf_we_o,
    output logic [1:0]               wb_sel_o,
    output logic                     alu_a_sel_o,
    output logic                     alu_b_sel_o,
    output logic [2:0]               state_o,
    output logic                     trap_o,
    output logic [1:0]               trap_cause_o,
    output logic [`XLEN-1:0]         instret_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_TRAP    = 3'd6
    } state_e;

    localparam state_e     RST_STATE = RESET_STATE_FETCH ? S_FETCH : S_IDLE;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [1:0]       cause_q, cause_d;
    logic [`XLEN-1:0] instret_q, instret_d;
    logic             retire;

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_imm, is_op, legal;

    assign is_lui    = (opcode_i == `OP_LUI);
    assign is_auipc  = (opcode_i == `OP_AUIPC);
    assign is_jal    = (opcode_i == `OP_JAL);
    assign is_jalr   = (opcode_i == `OP_JALR);
    assign is_branch = (opcode_i == `OP_BRANCH);
    assign is_load   = (opcode_i == `OP_LOAD);
    assign is_store  = (opcode_i == `OP_STORE);
    assign is_imm    = (opcode_i == `OP_IMM);
    assign is_op     = (opcode_i == `OP_OP);
    assign legal     = is_lui | is_auipc | is_jal | is_jalr | is_branch
                     | is_load | is_store | is_imm | is_op;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RST_STATE;
            wait_q    <= '0;
            cause_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    // The wait counter defaults to zero, so it clears on any ack or state change.
    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        cause_d     = cause_q;
        retire      = 1'b0;
        imem_req_o  = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        ir_en_o     = 1'b0;
        pc_en_o     = 1'b0;
        pc_sel_o    = 2'd0;
        rf_we_o     = 1'b0;
        wb_sel_o    = 2'd0;
        alu_a_sel_o = 1'b0;
        alu_b_sel_o = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_en_o = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end
            end
            S_EXECUTE: begin
                alu_a_sel_o = is_auipc;
                alu_b_sel_o = !(is_op || is_branch);
                if (is_branch) begin
                    pc_en_o  = 1'b1;
                    pc_sel_o = branch_taken_i ? 2'd1 : 2'd0;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = is_store;
                if (dmem_ack_i) begin
                    if (is_store) begin
                        pc_en_o = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = 2'd3;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                rf_we_o = 1'b1;
                pc_en_o = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
                if (is_load)                wb_sel_o = 2'd1;
                else if (is_jal || is_jalr) wb_sel_o = 2'd2;
                else if (is_lui)            wb_sel_o = 2'd3;
                if (is_jal)       pc_sel_o = 2'd1;
                else if (is_jalr) pc_sel_o = 2'd2;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        instret_d = retire ? instret_q + `XLEN'(1) : instret_q;
    end

    assign state_o      = state_q;
    assign trap_o       = (state_q == S_TRAP);
    assign trap_cause_o = cause_q;
    assign instret_o    = instret_q;

endmodule
